sad_window_unit: RTL

- Hardware SAD engine in the EX stage, directly downstream of the ID-stage register file.
- Consumes the register values the register file exposes on its dedicated read ports: frame base, target window base, frame columns, window rows/cols, x, y.
- Walks the window row-major, issuing paired word reads to data memory and accumulating |frame - window|.
- Returns one SAD result per Start, for the datapath to write back in place of the software inner loop.

---
 rtl/sad_window_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sad_window_unit.sv
// Sum-of-absolute-differences engine: walks a WinRows x WinCols window row-major,
// reading frame/window words in pairs and accumulating a saturating |A-B| sum.
module sad_window_unit #(
  parameter int DATA_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] FrameBase,
  input  logic [DATA_W-1:0] WindowBase,
  input  logic [DIM_W-1:0]  FrameCols,
  input  logic [DIM_W-1:0]  WinRows,
  input  logic [DIM_W-1:0]  WinCols,
  input  logic [DIM_W-1:0]  X,
  input  logic [DIM_W-1:0]  Y,
  output logic [DATA_W-1:0] MemAddrA,
  output logic [DATA_W-1:0] MemAddrB,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemDataA,
  input  logic [DATA_W-1:0] MemDataB,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] SadOut
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [DATA_W-1:0] WORD_BYTES = DATA_W'(3'd4);
  localparam logic [DIM_W-1:0]  DIM_ONE    = DIM_W'(1'b1);
  localparam logic [DIM_W-1:0]  DIM_ZERO   = {DIM_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};

  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    if (a >= b) abs_diff = a - b;
    else        abs_diff = b - a;
  endfunction

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[DATA_W]) sat_add = {DATA_W{1'b1}};
    else             sat_add = sum[DATA_W-1:0];
  endfunction

  state_t            state_r;
  logic [DATA_W-1:0] frame_base_r, win_base_r, row_ptr_r, acc_r;
  logic [DIM_W-1:0]  frame_cols_r, win_rows_r, win_cols_r, x_r, y_r;
  logic [DIM_W-1:0]  i_r, j_r;
  logic              valid_r;

  logic [2*DIM_W-1:0] prod_s;
  logic [DATA_W-1:0]  offset_s, row_start_s, stride_s, acc_next_s;
  logic               last_col_s, last_row_s, empty_s;

  // Address arithmetic for the window origin and the per-row stride.
  always_comb begin
    prod_s      = {{DIM_W{1'b0}}, y_r} * {{DIM_W{1'b0}}, frame_cols_r};
    offset_s    = DATA_W'(prod_s) + DATA_W'(x_r);
    row_start_s = frame_base_r + (offset_s << 2'd2);
    stride_s    = DATA_W'(frame_cols_r) << 2'd2;
    last_col_s  = (j_r == win_cols_r - DIM_ONE);
    last_row_s  = (i_r == win_rows_r - DIM_ONE);
    empty_s     = (win_rows_r == DIM_ZERO) || (win_cols_r == DIM_ZERO);
  end

  // Saturating accumulate of the pair returned by memory this cycle.
  always_comb begin
    acc_next_s = acc_r;
    if (valid_r) acc_next_s = sat_add(acc_r, abs_diff(MemDataA, MemDataB));
    else         acc_next_s = acc_r;
  end

  // Control FSM, address generation and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r      <= IDLE;
      frame_base_r <= DATA_ZERO;
      win_base_r   <= DATA_ZERO;
      row_ptr_r    <= DATA_ZERO;
      acc_r        <= DATA_ZERO;
      frame_cols_r <= DIM_ZERO;
      win_rows_r   <= DIM_ZERO;
      win_cols_r   <= DIM_ZERO;
      x_r          <= DIM_ZERO;
      y_r          <= DIM_ZERO;
      i_r          <= DIM_ZERO;
      j_r          <= DIM_ZERO;
      valid_r      <= 1'b0;
      MemAddrA     <= DATA_ZERO;
      MemAddrB     <= DATA_ZERO;
      MemRead      <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      SadOut       <= DATA_ZERO;
    end else begin
      valid_r <= MemRead;
      acc_r   <= acc_next_s;
      case (state_r)
        IDLE: begin
          if (Start) begin
            frame_base_r <= FrameBase;
            win_base_r   <= WindowBase;
            frame_cols_r <= FrameCols;
            win_rows_r   <= WinRows;
            win_cols_r   <= WinCols;
            x_r          <= X;
            y_r          <= Y;
            acc_r        <= DATA_ZERO;
            SadOut       <= DATA_ZERO;
            Busy         <= 1'b1;
            state_r      <= SETUP;
          end
        end
        SETUP: begin
          i_r       <= DIM_ZERO;
          j_r       <= DIM_ZERO;
          row_ptr_r <= row_start_s;
          // An empty window still passes through DRAIN so Done lands at the same N+2 offset.
          if (empty_s) begin
            state_r <= DRAIN;
          end else begin
            MemRead  <= 1'b1;
            MemAddrA <= row_start_s;
            MemAddrB <= win_base_r;
            state_r  <= ISSUE;
          end
        end
        ISSUE: begin
          if (last_col_s && last_row_s) begin
            MemRead <= 1'b0;
            state_r <= DRAIN;
          end else if (last_col_s) begin
            j_r       <= DIM_ZERO;
            i_r       <= i_r + DIM_ONE;
            row_ptr_r <= row_ptr_r + stride_s;
            MemAddrA  <= row_ptr_r + stride_s;
            MemAddrB  <= MemAddrB + WORD_BYTES;
          end else begin
            j_r      <= j_r + DIM_ONE;
            MemAddrA <= MemAddrA + WORD_BYTES;
            MemAddrB <= MemAddrB + WORD_BYTES;
          end
        end
        DRAIN: begin
          Done    <= 1'b1;
          SadOut  <= acc_next_s;
          state_r <= DONE;
        end
        DONE: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          MemRead <= 1'b0;
          Busy    <= 1'b0;
          Done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
